// File: rtl/hash_job_sequencer.sv
// Job sequencer: walks entries 0..num_entradas, sweeps nonces through an external
// hash core and reports, per entry, whether a hash prefix below the bounty was found.
module hash_job_sequencer #(
    parameter int              BOUNTY_W  = 24,
    parameter int              PTR_W     = 2,
    parameter int              NONCE_W   = 32,
    parameter longint unsigned MAX_TRIES = 256,
    parameter int              TIMEOUT   = 64
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                start,
    input  logic [BOUNTY_W-1:0] bounty,
    input  logic [PTR_W-1:0]    num_entradas,
    output logic [PTR_W-1:0]    rd_ptr,
    output logic                hash_req,
    output logic [NONCE_W-1:0]  nonce,
    input  logic                hash_ack,
    input  logic                hash_valid,
    input  logic [BOUNTY_W-1:0] hash_out,
    output logic [BOUNTY_W-1:0] bounty_out,
    output logic                found_valid,
    output logic                found_ok,
    output logic [NONCE_W-1:0]  found_nonce,
    output logic                busy,
    output logic                error,
    output logic                fin,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_REPORT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int                 TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0]      TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [NONCE_W-1:0] LAST_NONCE = NONCE_W'(MAX_TRIES - 1);

    state_t             state, next_state;
    logic [PTR_W-1:0]   num_q;
    logic [TW-1:0]      tmo_cnt;
    logic               accept, take, hit, give_up, retry, timed_out, tick, advance;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state <= S_IDLE;
        else          state <= next_state;
    end

    // Core handshake: a request transfers on any rising edge where hash_req and
    // hash_ack are both high; hash_req and nonce stay constant until then.
    // hash_valid is a one-cycle result strobe and only means something in S_WAIT.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        take       = 1'b0;
        hit        = 1'b0;
        give_up    = 1'b0;
        retry      = 1'b0;
        timed_out  = 1'b0;
        tick       = 1'b0;
        advance    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (hash_ack) begin
                    take       = 1'b1;
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (hash_valid) begin
                    if (hash_out < bounty_out) begin
                        hit        = 1'b1;
                        next_state = S_REPORT;
                    end else if (nonce == LAST_NONCE) begin
                        give_up    = 1'b1;
                        next_state = S_REPORT;
                    end else begin
                        retry      = 1'b1;
                        next_state = S_ISSUE;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    timed_out  = 1'b1;
                    next_state = S_DONE;
                end else begin
                    tick = 1'b1;
                end
            end
            S_REPORT: begin
                if (rd_ptr == num_q) begin
                    next_state = S_DONE;
                end else begin
                    advance    = 1'b1;
                    next_state = S_ISSUE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Status flags are registered from next_state so they line up with the state.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd_ptr      <= '0;
            hash_req    <= 1'b0;
            nonce       <= '0;
            bounty_out  <= '0;
            num_q       <= '0;
            tmo_cnt     <= '0;
            found_valid <= 1'b0;
            found_ok    <= 1'b0;
            found_nonce <= '0;
            busy        <= 1'b0;
            error       <= 1'b0;
            fin         <= 1'b0;
        end else begin
            hash_req    <= (next_state == S_ISSUE);
            busy        <= (next_state == S_ISSUE) || (next_state == S_WAIT) ||
                           (next_state == S_REPORT);
            fin         <= (next_state == S_DONE);
            found_valid <= (next_state == S_REPORT);
            if (accept) begin
                bounty_out <= bounty;
                num_q      <= num_entradas;
                rd_ptr     <= '0;
                nonce      <= '0;
                error      <= 1'b0;
            end
            if (take) tmo_cnt <= '0;
            if (tick) tmo_cnt <= tmo_cnt + 1'b1;
            if (retry) nonce <= nonce + 1'b1;
            // On give-up the nonce already equals MAX_TRIES-1.
            if (hit || give_up) begin
                found_ok    <= hit;
                found_nonce <= nonce;
            end
            if (timed_out) error <= 1'b1;
            if (advance) begin
                rd_ptr <= rd_ptr + 1'b1;
                nonce  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hash_job_sequencer.sv
// Directed bench for hash_job_sequencer; the bench plays the hash core from negedge
// to negedge and checks outputs with immediate assertions.
module tb_hash_job_sequencer;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        start;
    logic [23:0] bounty;
    logic [1:0]  num_entradas;
    logic [1:0]  rd_ptr;
    logic        hash_req;
    logic [31:0] nonce;
    logic        hash_ack;
    logic        hash_valid;
    logic [23:0] hash_out;
    logic [23:0] bounty_out;
    logic        found_valid;
    logic        found_ok;
    logic [31:0] found_nonce;
    logic        busy;
    logic        error;
    logic        fin;
    logic [2:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    // Small MAX_TRIES and TIMEOUT so the give-up and timeout paths are short.
    hash_job_sequencer #(
        .BOUNTY_W(24), .PTR_W(2), .NONCE_W(32), .MAX_TRIES(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset_L(reset_L), .start(start), .bounty(bounty),
        .num_entradas(num_entradas), .rd_ptr(rd_ptr), .hash_req(hash_req),
        .nonce(nonce), .hash_ack(hash_ack), .hash_valid(hash_valid),
        .hash_out(hash_out), .bounty_out(bounty_out), .found_valid(found_valid),
        .found_ok(found_ok), .found_nonce(found_nonce), .busy(busy),
        .error(error), .fin(fin), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (hash_req === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    // One nonce: immediate ack, result one cycle later. Returns at the negedge
    // after the deciding edge.
    task automatic serve(input logic [23:0] h, input int exp_n, input string tag);
        bit ok;
        wait_req(20, ok);
        check({tag, "_req"}, ok, 1'b1);
        check({tag, "_nonce"}, nonce, exp_n);
        hash_ack = 1'b1;
        @(negedge clk);
        hash_ack = 1'b0;
        check({tag, "_drop"}, hash_req, 1'b0);
        hash_out   = h;
        hash_valid = 1'b1;
        @(negedge clk);
        hash_valid = 1'b0;
        hash_out   = '0;
    endtask

    task automatic pulse_start(input logic [23:0] b, input logic [1:0] n);
        bounty       = b;
        num_entradas = n;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [127:0] all_outs();
        return {rd_ptr, hash_req, nonce, bounty_out, found_valid, found_ok,
                found_nonce, busy, error, fin};
    endfunction

    initial begin
        bit ok;
        reset_L = 1'b0; start = 1'b0; bounty = '0; num_entradas = '0;
        hash_ack = 1'b0; hash_valid = 1'b0; hash_out = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), '0);
        reset_L = 1'b1;
        @(negedge clk);
        check("idle_outs", all_outs(), '0);

        // 1: single entry, hit on nonce 0
        pulse_start(24'h000100, 2'd0);
        check("t1_req_busy", {hash_req, busy, fin}, 3'b110);
        serve(24'h0000FF, 0, "t1");
        check("t1_found", {found_valid, found_ok, rd_ptr, busy, fin}, {1'b1, 1'b1, 2'd0, 1'b1, 1'b0});
        check("t1_fnonce", found_nonce, 32'd0);
        check("t1_bounty_out", bounty_out, 24'h000100);
        @(negedge clk);
        check("t1_fin", {fin, busy, found_valid, error}, 4'b1000);
        check("t1_hold", {found_ok, found_nonce}, {1'b1, 32'd0});

        // 2: four entries, each hits on nonce 2
        pulse_start(24'h000100, 2'd3);
        check("t2_fin_clr", {fin, busy}, 2'b01);
        for (int e = 0; e < 4; e++) begin
            serve(24'h000200, 0, "t2_n0");
            serve(24'h000100, 1, "t2_n1");
            check("t2_nohit", found_valid, 1'b0);
            serve(24'h000050, 2, "t2_n2");
            check("t2_found", {found_valid, found_ok, rd_ptr}, {1'b1, 1'b1, 2'(e)});
            check("t2_fnonce", found_nonce, 32'd2);
            @(negedge clk);
            check("t2_pulse_end", found_valid, 1'b0);
            if (e < 3) begin
                check("t2_next", {rd_ptr, nonce, hash_req, fin}, {2'(e + 1), 32'd0, 1'b1, 1'b0});
                check("t2_keep_nonce", found_nonce, 32'd2);
            end else begin
                check("t2_fin", {fin, busy, rd_ptr}, {1'b1, 1'b0, 2'd3});
            end
        end

        // 3: hash equals bounty on every nonce -> give up after MAX_TRIES=4
        pulse_start(24'h000100, 2'd0);
        for (int n = 0; n < 3; n++) begin
            serve(24'h000100, n, "t3_miss");
            check("t3_no_found", found_valid, 1'b0);
        end
        serve(24'h000100, 3, "t3_last");
        check("t3_found", {found_valid, found_ok, found_nonce}, {1'b1, 1'b0, 32'd3});
        @(negedge clk);
        check("t3_fin", {fin, busy, error, found_ok, found_nonce}, {1'b1, 1'b0, 1'b0, 1'b0, 32'd3});

        // 4: ack but no result -> error and fin exactly 8 cycles after the ack edge
        pulse_start(24'h000100, 2'd0);
        wait_req(20, ok);
        check("t4_req", ok, 1'b1);
        hash_ack = 1'b1;
        @(negedge clk);
        hash_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("t4_waiting", {error, fin, busy, found_valid}, 4'b0010);
            @(negedge clk);
        end
        check("t4_timeout", {error, fin, busy, found_valid}, 4'b1100);
        hash_out   = 24'h000001;
        hash_valid = 1'b1;
        @(negedge clk);
        hash_valid = 1'b0;
        @(negedge clk);
        check("t4_late_valid", {found_valid, error, fin}, 3'b011);

        // 6: start from DONE clears error/fin; delayed ack with a start while busy
        pulse_start(24'h000100, 2'd0);
        check("t6_clear", {error, fin, hash_req, nonce}, {1'b0, 1'b0, 1'b1, 32'd0});
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                start = 1'b1; bounty = 24'h000001; num_entradas = 2'd3;
            end else begin
                start = 1'b0;
            end
            check("t6_stable", {hash_req, nonce, busy}, {1'b1, 32'd0, 1'b1});
            @(negedge clk);
        end
        start = 1'b0;
        check("t6_bounty_kept", bounty_out, 24'h000100);
        serve(24'h000080, 0, "t6");
        check("t6_found", {found_valid, found_ok, found_nonce, rd_ptr}, {1'b1, 1'b1, 32'd0, 2'd0});
        @(negedge clk);
        check("t6_fin", {fin, busy, error}, 3'b100);

        // 5: reset during WAIT of entry 1, then a clean two-entry job
        pulse_start(24'h000100, 2'd3);
        serve(24'h000010, 0, "t5_e0");
        check("t5_e0_found", {found_valid, rd_ptr}, {1'b1, 2'd0});
        @(negedge clk);
        wait_req(20, ok);
        check("t5_e1_req", {ok, rd_ptr}, {1'b1, 2'd1});
        hash_ack = 1'b1;
        @(negedge clk);
        hash_ack = 1'b0;
        #2 reset_L = 1'b0;
        #1 check("t5_async_reset", all_outs(), '0);
        @(negedge clk);
        check("t5_reset_held", all_outs(), '0);
        reset_L = 1'b1;
        @(negedge clk);
        check("t5_after_release", all_outs(), '0);
        pulse_start(24'h000100, 2'd1);
        serve(24'h000020, 0, "t5_r0");
        check("t5_r0_found", {found_valid, found_ok, rd_ptr}, {1'b1, 1'b1, 2'd0});
        @(negedge clk);
        serve(24'h000030, 0, "t5_r1");
        check("t5_r1_found", {found_valid, found_ok, rd_ptr}, {1'b1, 1'b1, 2'd1});
        @(negedge clk);
        check("t5_fin", {fin, busy, error, rd_ptr}, {1'b1, 1'b0, 1'b0, 2'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hash_job_sequencer.md
Name: hash_job_sequencer

Overview:
- Parametrised successor of the fixed 24-bit, 4-entry bounty/entry-pointer control interface used by the hash generator.
- Walks entries 0..num_entradas. For each entry it sweeps nonces through an external hash core with a request/response handshake and compares the hash against the latched bounty.
- Reports one result per entry, then raises fin.
- Sits between the top-level job interface and the hash core.

Parameters:
BOUNTY_W, 24, width of bounty and of the compared hash prefix
PTR_W, 2, entry-pointer width; up to 2**PTR_W entries per job
NONCE_W, 32, nonce width
MAX_TRIES, 256, nonces tried per entry before giving up (1..2**NONCE_W)
TIMEOUT, 64, max cycles from request to hash_valid before abort (>=2)

Ports:
clk  in  1  clock, rising edge
reset_L  in  1  asynchronous active-low reset
start  in  1  one-cycle job start; accepted only in IDLE or DONE
bounty  in  BOUNTY_W  target; latched on accepted start
num_entradas  in  PTR_W  highest entry index to process; latched on start
rd_ptr  out  PTR_W  index of the entry currently processed or reported
hash_req  out  1  request to hash core; held until hash_ack
nonce  out  NONCE_W  nonce for current request; stable while hash_req=1
hash_ack  in  1  core accepts request (hash_req & hash_ack = transfer)
hash_valid  in  1  one-cycle pulse, result available
hash_out  in  BOUNTY_W  hash prefix, valid with hash_valid
bounty_out  out  BOUNTY_W  latched bounty
found_valid  out  1  one-cycle pulse per completed entry
found_ok  out  1  1 = hash_out < bounty found; valid with found_valid
found_nonce  out  NONCE_W  winning nonce, or MAX_TRIES-1 on failure
busy  out  1  high in ISSUE/WAIT/REPORT
error  out  1  sticky timeout flag; cleared on accepted start
fin  out  1  high in DONE until next accepted start

Behaviour:
- Reset (async, reset_L=0) forces all outputs to 0 and the state to IDLE. Reset mid-job aborts it with no result or fin.
- State IDLE:
  - start=1 latches bounty into bounty_out and num_entradas.
  - Clears rd_ptr, nonce and error; goes to ISSUE.
  - start is ignored while busy.
- State ISSUE:
  - hash_req=1 with the current nonce.
  - On hash_ack=1, drop hash_req next cycle, clear the timeout counter and go to WAIT.
  - hash_ack arriving in the same cycle hash_req first rises is legal (transfer in 1 cycle).
- State WAIT:
  - Count cycles. On hash_valid, compare hash_out < bounty_out (unsigned, BOUNTY_W bits); hash_out == bounty is a failure.
    - Hit: go to REPORT with found_ok=1 and found_nonce=nonce.
    - Miss with nonce < MAX_TRIES-1: nonce+1, go to ISSUE.
    - Miss with nonce == MAX_TRIES-1: go to REPORT with found_ok=0 and found_nonce=MAX_TRIES-1.
  - Timeout counter reaching TIMEOUT without hash_valid: set error=1, go to DONE; no found_valid for that entry.
  - hash_valid outside WAIT is ignored.
- State REPORT:
  - found_valid=1 for exactly one cycle; rd_ptr still shows the reported entry.
  - If rd_ptr == num_entradas, go to DONE.
  - Otherwise rd_ptr+1, nonce=0, go to ISSUE.
  - num_entradas = 2**PTR_W-1 ends at the last index; rd_ptr never wraps.
- State DONE:
  - fin=1 and busy=0; rd_ptr holds its last value.
  - start=1 behaves as in IDLE and clears fin the next cycle.
- Timing:
  - Latency per nonce = ack latency + hash latency + 1 cycle.
  - found_valid occurs 1 cycle after the deciding hash_valid.
  - fin rises 1 cycle after the last found_valid.
- Outputs are registered; found_ok and found_nonce hold their value until the next REPORT.

Test Plan:
1. Defaults; bounty=24'h000100, num_entradas=0; core answers hash_out=24'h0000FF on nonce 0 (ack and valid 1 cycle each) -> found_valid with found_ok=1, found_nonce=0, rd_ptr=0; fin high the next cycle; bounty_out=24'h000100.
2. num_entradas=3; core hits on nonce 2 for every entry -> four found_valid pulses with rd_ptr 0,1,2,3, found_nonce=2 each; fin after the fourth; busy low at fin.
3. MAX_TRIES=4; core always returns hash_out=bounty -> 4 requests (nonce 0..3), then found_ok=0, found_nonce=3; the equality case confirmed as failure.
4. TIMEOUT=8; core acks but never asserts hash_valid -> error=1 and fin=1 exactly 8 cycles after ack; no found_valid.
5. Assert reset_L=0 while in WAIT of entry 1 -> all outputs 0 immediately. After release, a new start with num_entradas=1 completes normally from rd_ptr=0.
6. hash_ack delayed 5 cycles; start pulsed while busy -> nonce and hash_req stable until ack; the busy-time start is ignored; a start in DONE clears error and fin and restarts.
